// File: rtl/sha256_round_engine.sv
// SHA-256 compression round engine: one round per clock, 64 rounds per block, Block counts finished blocks.
// Latency: done pulses 65 cycles after start is sampled; start is ignored while busy or done. Optional abort via SHA256_ROUND_ABORT_EN.
module sha256_round_engine #(
    parameter int MAX_BLOCKS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         first,
    input  logic [511:0] block_in,
    input  logic [255:0] chain_in,
`ifdef SHA256_ROUND_ABORT_EN
    input  logic         abort,
`endif
    output logic [31:0]  a_out,
    output logic [31:0]  b_out,
    output logic [31:0]  c_out,
    output logic [31:0]  d_out,
    output logic [31:0]  e_out,
    output logic [31:0]  f_out,
    output logic [31:0]  g_out,
    output logic [31:0]  h_out,
    output logic [1:0]   Block,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [1:0] BLK_MAX = 2'(MAX_BLOCKS);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  rnd_q, rnd_d;
    logic [1:0]  blk_q, blk_d;
    logic [31:0] v_q [8];
    logic [31:0] v_d [8];
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic [31:0] out_q [8];
    logic [31:0] out_d [8];
`ifdef SHA256_ROUND_ABORT_EN
    logic [1:0]  blk_pre_q, blk_pre_d;
`endif

    logic [31:0] t1, t2, w_new;
    logic [31:0] nv [8];

    // Single round datapath; w_q[0] is W[t], w_new is W[t+16].
    always_comb begin
        t1 = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
           + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[rnd_q] + w_q[0];
        t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
           + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        nv[0] = t1 + t2;
        nv[1] = v_q[0];
        nv[2] = v_q[1];
        nv[3] = v_q[2];
        nv[4] = v_q[3] + t1;
        nv[5] = v_q[4];
        nv[6] = v_q[5];
        nv[7] = v_q[6];
        w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
              + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        v_d     = v_q;
        w_d     = w_q;
        out_d   = out_q;
`ifdef SHA256_ROUND_ABORT_EN
        blk_pre_d = blk_pre_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ROUND;
                    rnd_d   = 6'd0;
                    for (int i = 0; i < 8; i++)  v_d[i] = chain_in[255 - 32*i -: 32];
                    for (int i = 0; i < 16; i++) w_d[i] = block_in[511 - 32*i -: 32];
                    if (first) blk_d = 2'd0;
`ifdef SHA256_ROUND_ABORT_EN
                    blk_pre_d = blk_q;
`endif
                end
            end
            ROUND: begin
                v_d   = nv;
                rnd_d = rnd_q + 6'd1;
                for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                w_d[15] = w_new;
                if (rnd_q == 6'd63) begin
                    state_d = DONE;
                    out_d   = nv;
                    if (blk_q < BLK_MAX) blk_d = blk_q + 2'd1;
                end
`ifdef SHA256_ROUND_ABORT_EN
                // Abort leaves the visible state exactly as it was before start.
                if (abort) begin
                    state_d = IDLE;
                    out_d   = out_q;
                    blk_d   = blk_pre_q;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= 6'd0;
            blk_q   <= 2'd0;
            out_q   <= IV;
            v_q     <= IV;
`ifdef SHA256_ROUND_ABORT_EN
            blk_pre_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            out_q   <= out_d;
            v_q     <= v_d;
`ifdef SHA256_ROUND_ABORT_EN
            blk_pre_q <= blk_pre_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        w_q <= w_d;
    end

    assign a_out = out_q[0];
    assign b_out = out_q[1];
    assign c_out = out_q[2];
    assign d_out = out_q[3];
    assign e_out = out_q[4];
    assign f_out = out_q[5];
    assign g_out = out_q[6];
    assign h_out = out_q[7];
    assign Block = blk_q;
    assign busy  = (state_q == ROUND);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine: "abc" vector, Block counting, ignored starts, reset mid-round, back-to-back.
module tb_sha256_round_engine;

    logic         clk = 1'b0;
    logic         rst, start, first;
    logic [511:0] block_in;
    logic [255:0] chain_in;
    logic [31:0]  a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;
    logic [1:0]   Block;
    logic         busy, done;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [255:0] IV_C  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_R = 256'h506e3058d39a216504d24d6cb85e2ce95ef50f24fb121210948d25b6961f4894;
    localparam logic [511:0] ABC_B = {32'h61626380, 448'h0, 32'h00000018};

    sha256_round_engine #(.MAX_BLOCKS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .first(first),
        .block_in(block_in), .chain_in(chain_in),
        .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
        .e_out(e_out), .f_out(f_out), .g_out(g_out), .h_out(h_out),
        .Block(Block), .busy(busy), .done(done));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [255:0] exp);
        logic [255:0] cat;
        cat = {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out};
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_%0d", tag, i), cat[255 - 32*i -: 32], exp[255 - 32*i -: 32]);
    endtask

    // Runs 75 cycles from the start request; optionally re-pulses start (with first=1
    // and a different block) at round 10, round 63 and the done cycle.
    task automatic run_blk(input logic f, input logic [511:0] b, input bit glitch,
                           output int lat, output int ndone, output int nbusy);
        start = 1'b1; first = f; block_in = b; chain_in = IV_C;
        lat = 0; ndone = 0; nbusy = 0;
        for (int cyc = 1; cyc <= 75; cyc++) begin
            step();
            block_in = ~b;
            start    = glitch && (cyc == 11 || cyc == 64 || cyc == 65);
            first    = glitch ? 1'b1 : f;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat == 0) lat = cyc;
            end
        end
        start = 1'b0;
        first = 1'b0;
    endtask

    initial begin
        int lat, nd, nb, t1, t2;
        rst = 1'b1; start = 1'b0; first = 1'b0; block_in = '0; chain_in = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_blk", 32'(Block), 32'd0);
        chk_outs("rst_iv", IV_C);

        run_blk(1'b1, ABC_B, 1'b0, lat, nd, nb);
        chk("abc_lat", 32'(lat), 32'd65);
        chk("abc_ndone", 32'(nd), 32'd1);
        chk("abc_nbusy", 32'(nb), 32'd64);
        chk_outs("abc_out", ABC_R);
        chk("abc_blk", 32'(Block), 32'd1);

        run_blk(1'b0, ABC_B, 1'b0, lat, nd, nb);
        chk("blk2", 32'(Block), 32'd2);
        run_blk(1'b0, ABC_B, 1'b0, lat, nd, nb);
        chk("blk_sat", 32'(Block), 32'd2);

        start = 1'b1; first = 1'b1; block_in = ABC_B; chain_in = IV_C;
        step();
        start = 1'b0; first = 1'b0;
        chk("blk_clear", 32'(Block), 32'd0);
        lat = 0;
        for (int cyc = 2; cyc <= 120 && lat == 0; cyc++) begin
            step();
            if (done) lat = cyc;
        end
        chk("clear_lat", 32'(lat), 32'd65);
        chk("clear_blk", 32'(Block), 32'd1);
        step();

        run_blk(1'b0, ABC_B, 1'b1, lat, nd, nb);
        chk("ign_lat", 32'(lat), 32'd65);
        chk("ign_ndone", 32'(nd), 32'd1);
        chk("ign_blk", 32'(Block), 32'd2);
        chk_outs("ign_out", ABC_R);

        start = 1'b1; first = 1'b0; block_in = ABC_B; chain_in = IV_C;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            step();
            start = 1'b0;
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_blk", 32'(Block), 32'd0);
        chk("mid_rst_a", a_out, 32'h6a09e667);
        nd = 0;
        for (int cyc = 0; cyc < 70; cyc++) begin
            step();
            if (done) nd++;
        end
        chk("mid_rst_ndone", 32'(nd), 32'd0);

        start = 1'b1; first = 1'b1; block_in = ABC_B; chain_in = IV_C;
        t1 = 0; t2 = 0;
        for (int cyc = 1; cyc <= 200 && t2 == 0; cyc++) begin
            step();
            if (done) begin
                if (t1 == 0) t1 = cyc;
                else t2 = cyc;
            end
        end
        start = 1'b0;
        chk("b2b_first", 32'(t1), 32'd65);
        chk("b2b_period", 32'(t2 - t1), 32'd66);
        chk_outs("b2b_out", ABC_R);
        chk("b2b_blk", 32'(Block), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_round_engine.md
SHA256_ROUND_ENGINE -- requirements
Module: sha256_round_engine

Interface
REQ-001 MAX_BLOCKS, 2, number of 512-bit blocks per message; the Block count saturates at this value.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request to compress one block; sampled only in IDLE.
REQ-005 first  input  1  qualifies start: this block opens a new message.
REQ-006 block_in  input  512  message block; word 0 = bits [511:480].
REQ-007 chain_in  input  256  initial a..h; a = bits [255:224], h = bits [31:0].
REQ-008 a_out..h_out  output  32 each  working variables after round 63, before feed-forward.
REQ-009 Block  output  2  completed compressions in the current message; drives the H0..H7 feed-forward stages.
REQ-010 busy  output  1  high while rounds are in progress.
REQ-011 done  output  1  one-cycle pulse when a_out..h_out become valid.

Function
REQ-012 The FSM SHALL have states IDLE, ROUND and DONE.
  - IDLE->ROUND on start.
  - ROUND->DONE after round 63.
  - DONE->IDLE unconditionally.
REQ-013 On the edge sampling start in IDLE, the block SHALL:
  - load a..h from chain_in;
  - load the 16-word W window from block_in;
  - clear the round counter to 0;
  - clear Block to 0 if first=1.
REQ-014 Rounds 0..63 SHALL execute one per edge on the 64 edges following the start edge, using standard SHA-256 T1/T2, Ch, Maj, Sigma0 and Sigma1.
REQ-015 All additions SHALL be modulo 2^32; carries are discarded.
REQ-016 The K constants SHALL be held in an internal 64-entry ROM indexed by the round counter.
REQ-017 The W window SHALL shift one word per round.
  - For t>=16, the new word SHALL be sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16].
REQ-018 busy SHALL be high from the edge after start through the edge of round 63, i.e. 64 cycles.
REQ-019 done SHALL be high for exactly the one cycle following the round-63 edge.
  - a_out..h_out SHALL be valid in that cycle and held until the next accepted start.
REQ-020 Block SHALL increment on the same edge that asserts done, saturating at MAX_BLOCKS.
  - Block SHALL otherwise hold its value.
REQ-021 start asserted while busy or done is high SHALL be ignored, with no effect on state or outputs.
REQ-022 first SHALL have no effect unless start is accepted.
REQ-023 Back-to-back operation: start may be accepted in the cycle after done, giving a minimum of 66 cycles per block.

Reset
REQ-024 While rst=1 at an edge, the block SHALL enter IDLE, with priority over start.
REQ-025 On reset, busy=0, done=0, Block=0 and round counter=0.
REQ-026 On reset, a_out..h_out SHALL be set to the SHA-256 IV: 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
REQ-027 Reset asserted mid-ROUND SHALL abandon the block.
  - No done pulse SHALL follow.
  - Block SHALL NOT increment.

Configuration
REQ-028 With macro SHA256_ROUND_ABORT_EN defined, an input abort (1 bit) SHALL exist.
  - abort=1 during ROUND SHALL return the FSM to IDLE on that edge.
  - busy SHALL drop, with no done pulse.
  - Block and a_out..h_out SHALL be left unchanged from their pre-start values.
REQ-029 Without SHA256_ROUND_ABORT_EN, the abort port SHALL NOT exist and rounds always run to completion unless rst is asserted.

Verification
REQ-030 "abc" padded block, chain_in = IV, first=1 -> done 65 cycles after start; a_out=506e3058, c_out=04d24d6c; Block 0->1.
REQ-031 Two-block message, second start with first=0 -> Block goes 0->1->2; a third block leaves Block at 2; a new start with first=1 clears Block to 0.
REQ-032 start pulsed at rounds 10 and 63, and during the done cycle -> all ignored; exactly one done pulse; outputs identical to the single-start run.
REQ-033 rst asserted at round 30 -> next cycle busy=0, done never pulses, Block=0, a_out=6a09e667.
REQ-034 Macro defined, abort at round 40 -> busy=0 next cycle, no done, Block and outputs unchanged; a following start completes normally.
REQ-035 start held high continuously -> blocks accepted every 66 cycles; done period = 66.
